// File: rtl/spi_slave.sv
// spi_slave: LSB-first 8-bit SPI responder supporting all CPOL/CPHA modes,
// oversampling sclk/cs_n/mosi on clk and exchanging bytes with local logic.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       frame_abort,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t     state_q, state_d;
  logic [2:0] pin_s;
  logic       cs_s, sclk_s, mosi_s;
  logic       cs_p_q, sclk_p_q;
  logic       cpol_q, cpol_d, cpha_q, cpha_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0] hold_q, hold_d, rx_data_q, rx_data_d, rx_bits;
  logic       tx_ready_q, tx_ready_d, miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic       rx_valid_q, rx_valid_d, tx_underrun_q, tx_underrun_d;
  logic       frame_abort_q, frame_abort_d;
  logic       cs_fall, cs_rise, sclk_edge, lead, trail, samp, accept;
  if (SYNC_STAGES == 0) begin : g_direct
    assign pin_s = {cs_n, sclk, mosi};
  end else begin : g_sync
    logic [2:0] sync_q [SYNC_STAGES];
    // cs_n resets low so a select already held across reset never starts a partial frame
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '{default: '0};
      else begin
        sync_q[0] <= {cs_n, sclk, mosi};
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign pin_s = sync_q[SYNC_STAGES-1];
  end
  assign {cs_s, sclk_s, mosi_s} = pin_s;
  assign cs_fall   = cs_p_q & ~cs_s;
  assign cs_rise   = ~cs_p_q & cs_s;
  assign sclk_edge = sclk_s ^ sclk_p_q;
  assign lead      = sclk_edge & (sclk_s != cpol_q);
  assign trail     = sclk_edge & (sclk_s == cpol_q);
  assign samp      = cpha_q ? trail : lead;
  assign accept    = tx_load & tx_ready_q;
  always_comb begin
    state_d       = state_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_abort_d = 1'b0;
    hold_d        = accept ? tx_data : hold_q;
    tx_ready_d    = accept ? 1'b0 : tx_ready_q;
    rx_bits            = rx_shift_q;
    rx_bits[bit_cnt_q] = mosi_s;
    if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d       = ACTIVE;
        cpol_d        = cpol;
        cpha_d        = cpha;
        bit_cnt_d     = 3'd0;
        miso_oe_d     = 1'b1;
        tx_shift_d    = tx_ready_q ? 8'h00 : hold_q;
        tx_underrun_d = tx_ready_q;
        tx_ready_d    = ~accept;
        miso_d        = cpha ? 1'b0 : (tx_ready_q ? 1'b0 : hold_q[0]);
      end
    end else if (cs_rise) begin
      state_d       = IDLE;
      frame_abort_d = state_q == ACTIVE;
      miso_d        = 1'b0;
      miso_oe_d     = 1'b0;
    end else if (state_q == ACTIVE) begin
      if (samp) begin
        rx_shift_d = rx_bits;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d  = rx_bits;
          rx_valid_d = 1'b1;
          state_d    = DONE;
        end
      end
      if (cpha_q ? lead : trail) miso_d = tx_shift_q[cpha_q ? bit_cnt_q : bit_cnt_q + 3'd1];
      if (trail) bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cs_p_q        <= 1'b0;
      sclk_p_q      <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt_q     <= 3'd0;
      tx_shift_q    <= 8'h00;
      rx_shift_q    <= 8'h00;
      hold_q        <= 8'h00;
      rx_data_q     <= 8'h00;
      tx_ready_q    <= 1'b1;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_p_q        <= cs_s;
      sclk_p_q      <= sclk_s;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      hold_q        <= hold_d;
      rx_data_q     <= rx_data_d;
      tx_ready_q    <= tx_ready_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end
  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master driving spi_slave; received bytes are
// checked through a scoreboard queue, master-read bytes against constants.
module tb_spi_slave;
  localparam int HALF = 4;
  logic       clk = 1'b0, rst = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, busy;
  logic [7:0] rx_data, got;
  int         checks = 0, errors = 0;
  int         rv_cnt = 0, ur_cnt = 0, ab_cnt = 0, rv0, ur0, ab0;
  logic [7:0] exp_rx [$];

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
    .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .frame_abort(frame_abort),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_underrun) ur_cnt++;
    if (frame_abort) ab_cnt++;
    if (rx_valid) begin
      rv_cnt++;
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rx_unexpected: observed %0h expected no rx_valid", rx_data);
      end else chk("rx_data", rx_data, exp_rx.pop_front());
    end
  end

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic run_frame(input logic p, input logic h, input logic [7:0] mo, input int n,
                           input logic late, input logic [7:0] late_d, output logic [7:0] rd);
    rd = 8'h00;
    cpol = p;
    cpha = h;
    sclk = p;
    repeat (6) @(negedge clk);
    cs_n = 1'b0;
    mosi = h ? 1'b0 : mo[0];
    repeat (2) @(negedge clk);
    tx_data = late_d;
    tx_load = late;
    @(negedge clk);
    tx_load = 1'b0;
    repeat (HALF - 3) @(negedge clk);
    chk("miso_oe_active", miso_oe, 1'b1);
    chk("busy_active", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (h) mosi = i < 8 ? mo[i[2:0]] : 1'b0;
      if (!h && i < 8) rd[i[2:0]] = miso;
      sclk = ~p;
      repeat (HALF) @(negedge clk);
      if (h && i < 8) rd[i[2:0]] = miso;
      sclk = p;
      if (!h) mosi = i < 7 ? mo[3'(i + 1)] : 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic snap();
    rv0 = rv_cnt;
    ur0 = ur_cnt;
    ab0 = ab_cnt;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 1'b0);
    chk("rst_miso_oe", miso_oe, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_underrun", tx_underrun, 1'b0);
    chk("rst_frame_abort", frame_abort, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    snap();
    load(8'hA5);
    chk("tx_ready_after_load", tx_ready, 1'b0);
    load(8'hEE);
    exp_rx.push_back(8'h3C);
    run_frame(1'b0, 1'b0, 8'h3C, 8, 1'b0, 8'h00, got);
    chk("m0_master_read", got, 8'hA5);
    chk("m0_tx_ready", tx_ready, 1'b1);
    end_frame();
    chk("m0_rx_valid_count", rv_cnt - rv0, 1);
    chk("m0_no_underrun", ur_cnt - ur0, 0);

    snap();
    load(8'h99);
    run_frame(1'b0, 1'b0, 8'hFF, 5, 1'b0, 8'h00, got);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_miso_oe", miso_oe, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_pulse_count", ab_cnt - ab0, 1);
    chk("abort_no_rx_valid", rv_cnt - rv0, 0);
    chk("abort_rx_hold", rx_data, 8'h3C);

    for (int m = 1; m < 4; m++) begin
      snap();
      load(8'h81);
      exp_rx.push_back(8'h7E);
      run_frame(m[1], m[0], 8'h7E, 8, 1'b0, 8'h00, got);
      chk($sformatf("mode%0d_master_read", m), got, 8'h81);
      chk($sformatf("mode%0d_lsb_first", m), got[0], 1'b1);
      end_frame();
      chk($sformatf("mode%0d_rx_valid_count", m), rv_cnt - rv0, 1);
    end

    snap();
    exp_rx.push_back(8'h0F);
    run_frame(1'b0, 1'b0, 8'h0F, 8, 1'b1, 8'h55, got);
    chk("underrun_master_read", got, 8'h00);
    chk("underrun_pulse_count", ur_cnt - ur0, 1);
    chk("underrun_late_load_held", tx_ready, 1'b0);
    end_frame();
    snap();
    exp_rx.push_back(8'hC3);
    run_frame(1'b0, 1'b1, 8'hC3, 8, 1'b0, 8'h00, got);
    chk("after_underrun_master_read", got, 8'h55);
    chk("after_underrun_no_pulse", ur_cnt - ur0, 0);
    end_frame();

    snap();
    load(8'hF0);
    exp_rx.push_back(8'h5A);
    run_frame(1'b0, 1'b0, 8'h5A, 10, 1'b0, 8'h00, got);
    chk("extra_miso_hold", miso, 1'b1);
    chk("extra_busy", busy, 1'b1);
    chk("extra_master_read", got, 8'hF0);
    end_frame();
    chk("extra_rx_valid_count", rv_cnt - rv0, 1);

    snap();
    load(8'h77);
    run_frame(1'b0, 1'b0, 8'hAA, 3, 1'b0, 8'h00, got);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_miso", miso, 1'b0);
    chk("midrst_miso_oe", miso_oe, 1'b0);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_tx_ready", tx_ready, 1'b1);
    rst = 1'b0;
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_pulses", (rv_cnt - rv0) + (ab_cnt - ab0), 0);
    load(8'h12);
    exp_rx.push_back(8'h34);
    run_frame(1'b0, 1'b0, 8'h34, 8, 1'b0, 8'h00, got);
    chk("postrst_master_read", got, 8'h12);
    end_frame();
    chk("postrst_rx_valid_count", rv_cnt - rv0, 1);
    chk("rx_pending", exp_rx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
